mask_centroid: RTL and testbench

- Sits directly downstream of the YCbCr thresholding stage and consumes its binary mask stream (255 = object, 0 = background, replicated on all three bytes).
- Accumulates image moments m00 (area), m10 (sum x) and m01 (sum y) over each frame's foreground pixels.
- At end of frame, computes the centroid with a sequential divider.
- Passes the video stream through with one cycle of latency, optionally overlaying a crosshair at the last centroid.

---
 rtl/mask_centroid.sv | 233 +++++++++++++++++++++++
 tb/tb_mask_centroid.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_centroid.sv
// mask_centroid: accumulates mask moments per frame and divides them into a centroid.
// Optional crosshair overlay at the last centroid when CENTROID_MARKER_EN is defined.
module mask_centroid #(
    parameter int          CW         = 11,
    parameter int          AW         = 22,
    parameter int          MW         = 33,
    parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_in,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    input  logic [23:0]   pixel_in,
    output logic          de_out,
    output logic          h_sync_out,
    output logic          v_sync_out,
    output logic [23:0]   pixel_out,
    output logic [CW-1:0] x_c,
    output logic [CW-1:0] y_c,
    output logic [AW-1:0] area,
    output logic          centroid_valid,
    output logic          busy
);

    localparam int NW = $clog2(MW + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic          de_d;
    logic          vs_d;
    logic [23:0]   pix_d;
    logic          frame_end;
    logic          fg;
    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic [AW-1:0] m00;
    logic [MW-1:0] m10;
    logic [MW-1:0] m01;

    logic [AW-1:0] div_d;
    logic [MW-1:0] qx;
    logic [MW-1:0] qy;
    logic [AW-1:0] rx;
    logic [AW-1:0] ry;
    logic [NW-1:0] cnt;

    logic          load;
    logic          step;
    logic          finish;

    logic [AW:0]   dvs;
    logic [AW:0]   rx_sh;
    logic [AW:0]   ry_sh;
    logic          rx_ge;
    logic          ry_ge;
    logic [AW-1:0] rx_nx;
    logic [AW-1:0] ry_nx;

    assign frame_end  = v_sync_in & ~vs_d;
    assign fg         = de_in & pixel_in[23];
    assign de_out     = de_d;
    assign v_sync_out = vs_d;
    assign busy       = (state == DIV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_d       <= 1'b0;
            h_sync_out <= 1'b0;
            vs_d       <= 1'b0;
            pix_d      <= '0;
        end else begin
            de_d       <= de_in;
            h_sync_out <= h_sync_in;
            vs_d       <= v_sync_in;
            pix_d      <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (de_in) begin
                x_cnt <= x_cnt + 1'b1;
            end else begin
                x_cnt <= '0;
            end
            if (frame_end) begin
                y_cnt <= '0;
            end else if (de_d && !de_in) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    // A foreground pixel coincident with the frame edge seeds the new frame at row 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m00 <= '0;
            m10 <= '0;
            m01 <= '0;
        end else if (frame_end) begin
            m00 <= AW'(fg);
            m10 <= fg ? MW'(x_cnt) : '0;
            m01 <= '0;
        end else if (fg) begin
            m00 <= m00 + 1'b1;
            m10 <= m10 + MW'(x_cnt);
            m01 <= m01 + MW'(y_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_end) begin
                    load     = 1'b1;
                    state_nx = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (cnt == NW'(MW - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Restoring step: dividend shifts out of q's MSB while quotient bits shift in.
    always_comb begin
        dvs   = {1'b0, div_d};
        rx_sh = {rx, qx[MW-1]};
        ry_sh = {ry, qy[MW-1]};
        rx_ge = (rx_sh >= dvs);
        ry_ge = (ry_sh >= dvs);
        rx_nx = rx_ge ? AW'(rx_sh - dvs) : AW'(rx_sh);
        ry_nx = ry_ge ? AW'(ry_sh - dvs) : AW'(ry_sh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_d <= '0;
            qx    <= '0;
            qy    <= '0;
            rx    <= '0;
            ry    <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_d <= m00;
            qx    <= m10;
            qy    <= m01;
            rx    <= '0;
            ry    <= '0;
            cnt   <= '0;
        end else if (step) begin
            qx    <= {qx[MW-2:0], rx_ge};
            qy    <= {qy[MW-2:0], ry_ge};
            rx    <= rx_nx;
            ry    <= ry_nx;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_c            <= '0;
            y_c            <= '0;
            area           <= '0;
            centroid_valid <= 1'b0;
        end else begin
            centroid_valid <= finish;
            if (finish) begin
                if (div_d != '0) begin
                    x_c  <= qx[CW-1:0];
                    y_c  <= qy[CW-1:0];
                    area <= div_d;
                end else begin
                    x_c  <= '0;
                    y_c  <= '0;
                    area <= '0;
                end
            end
        end
    end

`ifdef CENTROID_MARKER_EN
    logic [CW-1:0] x_d;
    logic [CW-1:0] y_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_d <= '0;
            y_d <= '0;
        end else begin
            x_d <= x_cnt;
            y_d <= frame_end ? '0 : y_cnt;
        end
    end

    assign pixel_out = (de_d && (area != '0) && ((x_d == x_c) || (y_d == y_c)))
                       ? MARK_COLOR : pix_d;
`else
    assign pixel_out = pix_d;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Testbench for mask_centroid: table vectors, corner sequences and random frames
// checked against an arithmetic reference model.
module tb_mask_centroid;

    localparam int CW = 11;
    localparam int AW = 22;
    localparam int MW = 33;
`ifdef CENTROID_MARKER_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          de_in;
    logic          h_sync_in;
    logic          v_sync_in;
    logic [23:0]   pixel_in;
    logic          de_out;
    logic          h_sync_out;
    logic          v_sync_out;
    logic [23:0]   pixel_out;
    logic [CW-1:0] x_c;
    logic [CW-1:0] y_c;
    logic [AW-1:0] area;
    logic          centroid_valid;
    logic          busy;

    mask_centroid dut (
        .clk(clk),
        .rst_n(rst_n),
        .de_in(de_in),
        .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in),
        .pixel_in(pixel_in),
        .de_out(de_out),
        .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out),
        .pixel_out(pixel_out),
        .x_c(x_c),
        .y_c(y_c),
        .area(area),
        .centroid_valid(centroid_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        int x0;
        int x1;
        int y0;
        int y1;
        int ea;
        int ex;
        int ey;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cv_cnt   = 0;
    int cv_at    = -1;
    int cv_x     = 0;
    int cv_y     = 0;
    int cv_a     = 0;
    int m_area   = 0;
    int m_xc     = 0;
    int m_yc     = 0;
    bit img [0:63][0:63];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (centroid_valid) begin
            cv_cnt++;
            cv_at = cyc + 1;
            cv_x  = int'(x_c);
            cv_y  = int'(y_c);
            cv_a  = int'(area);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_pixel(input logic d, input logic [23:0] p,
                                              input int x, input int y);
        if (MARK && d && m_area != 0 && (x == m_xc || y == m_yc)) return 24'hFF0000;
        return p;
    endfunction

    task automatic tick_chk(input logic [23:0] exp_pix);
        logic d, h, v;
        d = de_in;
        h = h_sync_in;
        v = v_sync_in;
        tick();
        chk("de_out", int'(de_out), int'(d));
        chk("h_sync_out", int'(h_sync_out), int'(h));
        chk("v_sync_out", int'(v_sync_out), int'(v));
        chk("pixel_out", int'(pixel_out), int'(exp_pix));
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++)
                img[x][y] = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
    endtask

    // Reference: moments by plain summation, centroid by integer division.
    task automatic model(input int w, input int h, output int a, output int xc, output int yc);
        int sx, sy;
        a = 0;
        sx = 0;
        sy = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (img[x][y]) begin
                    a++;
                    sx += x;
                    sy += y;
                end
        xc = (a == 0) ? 0 : sx / a;
        yc = (a == 0) ? 0 : sy / a;
    endtask

    // Drives one frame and leaves v_sync raised; t_end is that cycle's number.
    task automatic run_frame(input int w, input int h, output int t_end);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                de_in     = 1'b1;
                h_sync_in = 1'b0;
                pixel_in  = img[x][y] ? 24'hFFFFFF : 24'h000000;
                tick_chk(exp_pixel(1'b1, pixel_in, x, y));
            end
            de_in    = 1'b0;
            pixel_in = 24'h0;
            for (int k = 0; k < 4; k++) begin
                h_sync_in = (k == 1);
                tick_chk(24'h0);
            end
        end
        h_sync_in = 1'b0;
        for (int k = 0; k < 3; k++) tick_chk(24'h0);
        v_sync_in = 1'b1;
        t_end = cyc + 1;
    endtask

    task automatic wait_result(input int t, input int ea, input int ex, input int ey,
                               input string tag);
        int nb;
        nb = 0;
        cv_cnt = 0;
        cv_at = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k == 2) v_sync_in = 1'b0;
            if (busy) nb++;
        end
        chk({tag, " pulses"}, cv_cnt, 1);
        chk({tag, " latency"}, cv_at - t, MW + 2);
        chk({tag, " busy_cycles"}, nb, MW);
        chk({tag, " area"}, cv_a, ea);
        chk({tag, " x_c"}, cv_x, ex);
        chk({tag, " y_c"}, cv_y, ey);
        m_area = ea;
        m_xc = ex;
        m_yc = ey;
    endtask

    task automatic do_reset();
        de_in = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        pixel_in = 24'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_area = 0;
        m_xc = 0;
        m_yc = 0;
    endtask

    initial begin
        int t, a, xc, yc, w, h, dens;
        logic d, hs, vs;
        logic [23:0] p;

        vecs[0] = '{16, 8, 5, 5, 3, 3, 1, 5, 3};
        vecs[1] = '{16, 8, 2, 5, 1, 2, 8, 3, 1};
        vecs[2] = '{16, 8, 0, 15, 0, 7, 128, 7, 3};
        vecs[3] = '{16, 8, 1, 0, 0, 7, 0, 0, 0};

        rst_n = 1'b0;
        de_in = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        pixel_in = 24'h0;
        repeat (3) tick();
        chk("reset x_c", int'(x_c), 0);
        chk("reset y_c", int'(y_c), 0);
        chk("reset area", int'(area), 0);
        chk("reset valid", int'(centroid_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset pixel_out", int'(pixel_out), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            set_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
            run_frame(vecs[i].w, vecs[i].h, t);
            wait_result(t, vecs[i].ea, vecs[i].ex, vecs[i].ey, $sformatf("vec%0d", i));
        end

        // Frame ending while the divider runs is discarded.
        set_rect(2, 5, 1, 2);
        run_frame(16, 8, t);
        cv_cnt = 0;
        repeat (3) tick();
        v_sync_in = 1'b0;
        for (int x = 0; x < 4; x++) begin
            de_in = 1'b1;
            pixel_in = 24'hFFFFFF;
            tick();
        end
        de_in = 1'b0;
        pixel_in = 24'h0;
        repeat (3) tick();
        v_sync_in = 1'b1;
        repeat (3) tick();
        v_sync_in = 1'b0;
        repeat (60) tick();
        chk("discard pulses", cv_cnt, 1);
        chk("discard latency", cv_at - t, MW + 2);
        chk("discard area", cv_a, 8);
        chk("discard x_c", cv_x, 3);
        chk("discard y_c", cv_y, 1);
        m_area = 8;
        m_xc = 3;
        m_yc = 1;

        set_rect(5, 5, 3, 3);
        run_frame(16, 8, t);
        wait_result(t, 1, 5, 3, "after_discard");

        // Reset pulse in the middle of a division.
        set_rect(2, 5, 1, 2);
        run_frame(16, 8, t);
        cv_cnt = 0;
        while (cyc + 1 < t + 10) begin
            tick();
            if (cyc == t + 2) v_sync_in = 1'b0;
        end
        do_reset();
        chk("abort x_c", int'(x_c), 0);
        chk("abort y_c", int'(y_c), 0);
        chk("abort area", int'(area), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort de_out", int'(de_out), 0);
        repeat (50) tick();
        chk("abort pulses", cv_cnt, 0);

        run_frame(16, 8, t);
        wait_result(t, 8, 3, 1, "after_abort");

        for (int k = 0; k < 200; k++) begin
            de_in = 1'($urandom);
            h_sync_in = 1'($urandom);
            v_sync_in = 1'($urandom);
            pixel_in = 24'($urandom);
            d = de_in;
            hs = h_sync_in;
            vs = v_sync_in;
            p = pixel_in;
            tick();
            chk("rnd de_out", int'(de_out), int'(d));
            chk("rnd h_sync_out", int'(h_sync_out), int'(hs));
            chk("rnd v_sync_out", int'(v_sync_out), int'(vs));
            if (!MARK || !d) chk("rnd pixel_out", int'(pixel_out), int'(p));
        end
        do_reset();

        for (int f = 0; f < 6; f++) begin
            w = $urandom_range(1, 24);
            h = $urandom_range(1, 12);
            dens = $urandom_range(0, 100);
            for (int x = 0; x < 64; x++)
                for (int y = 0; y < 64; y++)
                    img[x][y] = ($urandom_range(0, 99) < dens);
            model(w, h, a, xc, yc);
            run_frame(w, h, t);
            wait_result(t, a, xc, yc, $sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
